// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory handshake, IF/ID
// pipeline register with a one-entry skid buffer, and branch redirect/squash.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 18,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic                   BranchTakenE,
  input  logic [PC_WIDTH-1:0]    BranchTargetE,
  output logic                   ImemReq,
  output logic [PC_WIDTH-1:0]    ImemAddr,
  input  logic [INSTR_WIDTH-1:0] ImemRdata,
  input  logic                   ImemValid,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [PC_WIDTH-1:0]    PCPlus8D,
  output logic                   ValidD,
  output logic                   FetchStall
);

  // WAIT: request outstanding; SQUASH: outstanding request belongs to a
  // mispredicted path; HOLD: IF/ID stalled and skid buffer full.
  typedef enum logic [1:0] {IDLE, WAIT, SQUASH, HOLD} state_t;

  localparam logic [PC_WIDTH-1:0] PC_FOUR  = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] PC_EIGHT = PC_WIDTH'(8);

  state_t                 state, state_nx;
  logic [PC_WIDTH-1:0]    pc, pc_nx;
  logic [PC_WIDTH-1:0]    pending, pending_nx;
  logic [INSTR_WIDTH-1:0] skid_instr, skid_instr_nx;
  logic [PC_WIDTH-1:0]    skid_pc8, skid_pc8_nx;
  logic [INSTR_WIDTH-1:0] instr_nx;
  logic [PC_WIDTH-1:0]    pc8_nx;
  logic                   valid_nx;
  logic                   flush;
  logic                   accept;
  logic [PC_WIDTH-1:0]    pc_plus4, pc_plus8;

  assign flush      = FlushD | BranchTakenE;
  assign accept     = ~ValidD | ~StallD;
  assign pc_plus4   = pc + PC_FOUR;
  assign pc_plus8   = pc + PC_EIGHT;

  assign ImemReq    = (state == WAIT) || (state == SQUASH);
  assign ImemAddr   = pc;
  assign FetchStall = ImemReq & ~ImemValid;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_nx      = state;
    pc_nx         = pc;
    pending_nx    = pending;
    skid_instr_nx = skid_instr;
    skid_pc8_nx   = skid_pc8;
    instr_nx      = InstrD;
    pc8_nx        = PCPlus8D;
    valid_nx      = ValidD & StallD;  // Decode consumes the word unless stalled

    case (state)
      IDLE: begin
        if (BranchTakenE) pc_nx = BranchTargetE;
        else              state_nx = WAIT;
      end

      WAIT: begin
        if (ImemValid) begin
          if (BranchTakenE) begin
            pc_nx = BranchTargetE;
          end else begin
            pc_nx = pc_plus4;
            if (!FlushD) begin
              if (accept) begin
                instr_nx = ImemRdata;
                pc8_nx   = pc_plus8;
                valid_nx = 1'b1;
              end else begin
                skid_instr_nx = ImemRdata;
                skid_pc8_nx   = pc_plus8;
                state_nx      = HOLD;
              end
            end
          end
        end else if (BranchTakenE) begin
          // Address must stay stable until the memory answers.
          pending_nx = BranchTargetE;
          state_nx   = SQUASH;
        end
      end

      SQUASH: begin
        if (ImemValid) begin
          pc_nx    = BranchTakenE ? BranchTargetE : pending;
          state_nx = WAIT;
        end else if (BranchTakenE) begin
          pending_nx = BranchTargetE;
        end
      end

      HOLD: begin
        // The skid buffer is full exactly while in HOLD; leaving HOLD empties it.
        if (BranchTakenE) begin
          pc_nx    = BranchTargetE;
          state_nx = WAIT;
        end else if (FlushD) begin
          state_nx = WAIT;
        end else if (!StallD) begin
          instr_nx = skid_instr;
          pc8_nx   = skid_pc8;
          valid_nx = 1'b1;
          state_nx = WAIT;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (flush) begin
      instr_nx = '0;
      valid_nx = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pending    <= '0;
      skid_instr <= '0;
      skid_pc8   <= '0;
      InstrD     <= '0;
      PCPlus8D   <= '0;
      ValidD     <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      pending    <= pending_nx;
      skid_instr <= skid_instr_nx;
      skid_pc8   <= skid_pc8_nx;
      InstrD     <= instr_nx;
      PCPlus8D   <= pc8_nx;
      ValidD     <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory responder, a queue-based model
// of the Decode-side instruction stream, and directed scenarios.
module tb_fetch_stage;

  localparam int PCW = 18;
  localparam int IW  = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           StallD, FlushD, BranchTakenE;
  logic [PCW-1:0] BranchTargetE;
  logic           ImemReq;
  logic [PCW-1:0] ImemAddr;
  logic [IW-1:0]  ImemRdata;
  logic           ImemValid;
  logic [IW-1:0]  InstrD;
  logic [PCW-1:0] PCPlus8D;
  logic           ValidD, FetchStall;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int wait_cnt = 0;
  int cnt_valid, cnt_stall;

  // Model: fetched words waiting for Decode (head = IF/ID, at most two deep)
  logic           m_idle, m_squash;
  logic [PCW-1:0] m_pc, m_pending;
  logic [IW-1:0]  m_disp;
  logic [IW-1:0]  q_instr[$];
  logic [PCW-1:0] q_pc8[$];

  fetch_stage #(.PC_WIDTH(PCW), .RESET_PC('0), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .ImemValid(ImemValid), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .ValidD(ValidD), .FetchStall(FetchStall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle    = 1'b1;
    m_squash  = 1'b0;
    m_pc      = '0;
    m_pending = '0;
    m_disp    = '0;
    q_instr.delete();
    q_pc8.delete();
    wait_cnt  = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   32'(ImemReq),    32'h0);
    check({tag, "_addr"},  32'(ImemAddr),   32'h0);
    check({tag, "_instr"}, InstrD,          32'h0);
    check({tag, "_pc8"},   32'(PCPlus8D),   32'h0);
    check({tag, "_valid"}, 32'(ValidD),     32'h0);
    check({tag, "_stall"}, 32'(FetchStall), 32'h0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    ImemValid = 1'b0;
    ImemRdata = '0;
    #1;
    check_reset("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: answer memory, compare DUT against model, advance both.
  task automatic step();
    logic m_req, req_s, flush;
    m_req     = !m_idle && (q_instr.size() < 2);
    req_s     = ImemReq;
    ImemValid = req_s && (wait_cnt >= lat - 1);
    ImemRdata = ImemValid ? IW'(ImemAddr) : '0;
    #1;
    check("req",   32'(ImemReq),    32'(m_req));
    if (m_req) check("addr", 32'(ImemAddr), 32'(m_pc));
    check("stall", 32'(FetchStall), 32'(m_req && !ImemValid));
    check("valid", 32'(ValidD),     32'(q_instr.size() > 0));
    check("instr", InstrD,          m_disp);
    if (q_instr.size() > 0) check("pc8", 32'(PCPlus8D), 32'(q_pc8[0]));
    if (ValidD)     cnt_valid++;
    if (FetchStall) cnt_stall++;

    @(posedge clk);
    flush = FlushD | BranchTakenE;
    if (q_instr.size() > 0 && !StallD) begin
      q_instr.delete(0);
      q_pc8.delete(0);
    end
    if (m_req && ImemValid) begin
      if (m_squash || BranchTakenE) begin
        m_pc     = BranchTakenE ? BranchTargetE : m_pending;
        m_squash = 1'b0;
      end else begin
        q_instr.push_back(IW'(m_pc));
        q_pc8.push_back(m_pc + 18'd8);
        m_pc = m_pc + 18'd4;
      end
    end else if (m_req && BranchTakenE) begin
      m_squash  = 1'b1;
      m_pending = BranchTargetE;
    end else if (!m_req && BranchTakenE) begin
      m_pc = BranchTargetE;
    end
    if (m_idle && !BranchTakenE) m_idle = 1'b0;
    if (flush) begin
      q_instr.delete();
      q_pc8.delete();
      m_disp = '0;
    end else if (q_instr.size() > 0) begin
      m_disp = q_instr[0];
    end
    if (req_s && ImemValid) wait_cnt = 0;
    else if (req_s)         wait_cnt++;
    else                    wait_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] stall_pat;
    rst_n = 1'b1; StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0;
    BranchTargetE = '0; ImemValid = 1'b0; ImemRdata = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle memory: one instruction per cycle, PCPlus8D = InstrD + 8
    lat = 1;
    check("idle_no_req", 32'(ImemReq), 32'h0);
    step();
    check("first_req",  32'(ImemReq),  32'h1);
    check("first_addr", 32'(ImemAddr), 32'h0);
    step();
    check("i0_instr", InstrD,           32'h0);
    check("i0_pc8",   32'(PCPlus8D),    32'h8);
    check("i0_next",  32'(ImemAddr),    32'h4);
    step();
    check("i1_instr", InstrD,           32'h4);
    check("i1_pc8",   32'(PCPlus8D),    32'hC);
    check("i1_next",  32'(ImemAddr),    32'h8);
    repeat (3) step();

    // Three-cycle memory: two stall cycles per fetch, one ValidD per three
    lat = 3; cnt_valid = 0; cnt_stall = 0;
    repeat (9) step();
    check("lat3_stalls", 32'(cnt_stall), 32'd6);
    check("lat3_valids", 32'(cnt_valid), 32'd3);

    // Stall while the word for 0x10 returns: skid into HOLD, then release
    apply_reset();
    lat = 1;
    repeat (5) step();
    check("pre_hold_instr", InstrD,        32'hC);
    check("pre_hold_addr",  32'(ImemAddr), 32'h10);
    StallD = 1'b1;
    step();
    check("hold_req",   32'(ImemReq), 32'h0);
    check("hold_instr", InstrD,       32'hC);
    repeat (3) step();
    check("hold4_req",   32'(ImemReq), 32'h0);
    check("hold4_instr", InstrD,       32'hC);
    StallD = 1'b0;
    step();
    check("unhold_instr", InstrD,        32'h10);
    check("unhold_pc8",   32'(PCPlus8D), 32'h18);
    check("unhold_addr",  32'(ImemAddr), 32'h14);
    check("unhold_req",   32'(ImemReq),  32'h1);

    // Branch to 0x100 during a two-cycle fetch of 0x20
    apply_reset();
    lat = 1;
    repeat (9) step();
    check("pre_br_addr", 32'(ImemAddr), 32'h20);
    lat = 2;
    BranchTakenE = 1'b1; BranchTargetE = 18'h100;
    step();
    BranchTakenE = 1'b0;
    check("sq_addr",  32'(ImemAddr), 32'h20);
    check("sq_req",   32'(ImemReq),  32'h1);
    check("sq_valid", 32'(ValidD),   32'h0);
    step();
    check("br_addr",  32'(ImemAddr), 32'h100);
    check("br_valid", 32'(ValidD),   32'h0);
    repeat (2) step();
    check("br_instr", InstrD, 32'h100);

    // A second branch while squashing overwrites the pending target
    lat = 3;
    BranchTakenE = 1'b1; BranchTargetE = 18'h200;
    step();
    BranchTargetE = 18'h300;
    step();
    BranchTakenE = 1'b0;
    step();
    check("br2_addr", 32'(ImemAddr), 32'h300);

    // PC wrap at the top of the 18-bit space
    lat = 1;
    BranchTakenE = 1'b1; BranchTargetE = 18'h3FFFC;
    step();
    BranchTakenE = 1'b0;
    check("wrap_addr", 32'(ImemAddr), 32'h3FFFC);
    step();
    check("wrap_instr", InstrD,        32'h3FFFC);
    check("wrap_pc8",   32'(PCPlus8D), 32'h4);
    check("wrap_next",  32'(ImemAddr), 32'h0);

    // Flush beats stall in HOLD and drops the skid entry
    StallD = 1'b1;
    step();
    check("fh_hold_req", 32'(ImemReq), 32'h0);
    FlushD = 1'b1;
    step();
    FlushD = 1'b0; StallD = 1'b0;
    check("fh_valid", 32'(ValidD),  32'h0);
    check("fh_instr", InstrD,       32'h0);
    check("fh_req",   32'(ImemReq), 32'h1);
    repeat (3) step();

    // Mixed stall pattern with a flush, two-cycle memory
    lat = 2;
    stall_pat = 24'h3C5E0D;
    for (int i = 0; i < 24; i++) begin
      StallD = stall_pat[i];
      FlushD = (i == 10);
      step();
    end
    StallD = 1'b0; FlushD = 1'b0;

    // Reset in the middle of an outstanding request
    lat = 3;
    step();
    apply_reset();
    check("post_reset_addr", 32'(ImemAddr), 32'h0);
    lat = 1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, 18, width of PC and instruction-memory address.
REQ-002 SHALL have parameter RESET_PC, 0, PC value loaded on reset.
REQ-003 SHALL have parameter INSTR_WIDTH, 32, instruction word width.
REQ-004 SHALL have port clk  in  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port StallD  in  1  Decode stall; hold IF/ID register.
REQ-007 SHALL have port FlushD  in  1  Decode flush; bubble into IF/ID register.
REQ-008 SHALL have port BranchTakenE  in  1  redirect request from Execute.
REQ-009 SHALL have port BranchTargetE  in  PC_WIDTH  redirect target.
REQ-010 SHALL have port ImemReq  out  1  instruction-memory request.
REQ-011 SHALL have port ImemAddr  out  PC_WIDTH  request address; equals PC.
REQ-012 SHALL have port ImemRdata  in  INSTR_WIDTH  returned word, valid when ImemValid=1.
REQ-013 SHALL have port ImemValid  in  1  response strobe; completes the current request.
REQ-014 SHALL have port InstrD  out  INSTR_WIDTH  instruction presented to Decode.
REQ-015 SHALL have port PCPlus8D  out  PC_WIDTH  PC of InstrD plus 8 (R15 read value).
REQ-016 SHALL have port ValidD  out  1  InstrD holds a real instruction.
REQ-017 SHALL have port FetchStall  out  1  ImemReq=1 and ImemValid=0.

Function
REQ-018 SHALL implement states IDLE, WAIT, SQUASH, HOLD.
REQ-019 SHALL drive ImemReq=1 in WAIT and SQUASH only; ImemAddr SHALL stay stable while ImemReq=1 and ImemValid=0.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then move to WAIT.
REQ-021 In WAIT with ImemValid=1 and the IF/ID register accepting (ValidD=0 or StallD=0): SHALL load InstrD=ImemRdata, PCPlus8D=PC+8, ValidD=1, PC<=PC+4, stay WAIT (back-to-back throughput 1 instr/cycle).
REQ-022 In WAIT with ImemValid=1, ValidD=1, StallD=1: SHALL capture word and PC+8 in a one-entry skid buffer, PC<=PC+4, go HOLD.
REQ-023 In HOLD: ImemReq=0; when StallD=0 SHALL move skid buffer into IF/ID, go WAIT.
REQ-024 PC arithmetic SHALL be modulo 2^PC_WIDTH (PC+4 and PC+8 wrap silently).
REQ-025 FlushD=1 SHALL set ValidD=0, InstrD=0 next edge and empty the skid buffer (HOLD->WAIT); flush SHALL win over StallD.
REQ-026 BranchTakenE=1 SHALL also act as FlushD.
REQ-027 BranchTakenE in IDLE or HOLD: PC<=BranchTargetE, go WAIT (from HOLD) or stay IDLE.
REQ-028 BranchTakenE in WAIT with ImemValid=1: response discarded, PC<=BranchTargetE, stay WAIT.
REQ-029 BranchTakenE in WAIT with ImemValid=0: target stored in pending register, go SQUASH; address unchanged.
REQ-030 In SQUASH: a second BranchTakenE SHALL overwrite the pending target; on ImemValid=1 the response SHALL be discarded, PC<=pending target, go WAIT.
REQ-031 A response discarded under REQ-028/030 SHALL never reach InstrD or the skid buffer.
REQ-032 StallD=1 with ValidD=0 SHALL NOT block loading (empty register accepts).

Reset
REQ-033 rst_n=0 SHALL immediately set PC=RESET_PC, state IDLE, ImemReq=0, InstrD=0, PCPlus8D=0, ValidD=0, skid buffer empty, pending target 0, FetchStall=0.
REQ-034 Reset asserted mid-request SHALL abandon the request; no post-reset state SHALL depend on it.

Verification
REQ-035 Reset, memory returns valid every cycle with Rdata=addr -> ImemAddr 0,4,8,...; InstrD 0,4,8 one per cycle; PCPlus8D=InstrD+8.
REQ-036 Memory latency 3 cycles -> FetchStall=1 for 2 cycles per fetch, ValidD pulses once per 3 cycles.
REQ-037 ValidD=1, StallD=1 for 4 cycles while response for 0x10 returns -> state HOLD, ImemReq=0, InstrD unchanged; StallD drop -> InstrD=word@0x10 next cycle, next ImemAddr=0x14.
REQ-038 BranchTakenE target 0x100 during 2-cycle-latency fetch of 0x20 -> SQUASH, ImemAddr stays 0x20 until valid, word@0x20 dropped, next ImemAddr=0x100, ValidD=0 throughout.
REQ-039 PC=0x3FFFC (PC_WIDTH 18) fetched -> PCPlus8D=0x00004, next ImemAddr=0x00000.
REQ-040 FlushD and StallD both high in HOLD -> ValidD=0, InstrD=0, buffer emptied, ImemReq=1 next cycle; rst_n pulse mid-WAIT -> all outputs reset values immediately, ImemAddr=RESET_PC after release.
